sysahb_apb_bridge: RTL and testbench

- AHB-Lite slave to APB3 master bridge. Sits directly downstream of the E902 system AHB port, inside the system peripheral subsystem.
- Converts each AHB single transfer into one APB access and decodes the peripheral select from the address.
- Returns read data and error status to the CPU with AHB wait states.
- One outstanding transfer; no posting, no buffering beyond one captured address phase.

---
 rtl/sysahb_apb_bridge.sv | 201 ++++++++++++++++++++
 tb/tb_sysahb_apb_bridge.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysahb_apb_bridge.sv
// rtl/sysahb_apb_bridge.sv - AHB-Lite slave to APB3 master bridge
//
// One outstanding AHB single transfer is turned into one APB access; the
// 4-bit slot index haddr[SLOT_LSB+3:SLOT_LSB] picks a one-hot psel.
// Optional feature macro: SYSAHB_APB_PSTRB_EN (adds pstrb/pprot, rejects hsize>2).
//
// Ports:
//   sys_clk, sys_resetn        clock, async active-low reset
//   hsel/haddr/htrans/hwrite   AHB address phase
//   hsize/hprot                only used with SYSAHB_APB_PSTRB_EN
//   hwdata                     AHB write data (data phase)
//   hready                     bus-wide HREADY
//   hreadyout/hresp/hrdata     AHB slave response
//   paddr/psel/penable/pwrite  APB request
//   pwdata                     APB write data
//   prdata/pready/pslverr      APB response of the selected slave
//   pstrb/pprot                APB3+ extras (optional feature only)

module sysahb_apb_bridge #(
    parameter int NUM_SLAVES = 8,
    parameter int SLOT_LSB   = 12,
    parameter int PADDR_W    = 16
) (
    input  logic                  sys_clk,
    input  logic                  sys_resetn,
    input  logic                  hsel,
    input  logic [31:0]           haddr,
    input  logic [1:0]            htrans,
    input  logic                  hwrite,
    input  logic [2:0]            hsize,
    input  logic [3:0]            hprot,
    input  logic [31:0]           hwdata,
    input  logic                  hready,
    output logic                  hreadyout,
    output logic                  hresp,
    output logic [31:0]           hrdata,
    output logic [PADDR_W-1:0]    paddr,
    output logic [NUM_SLAVES-1:0] psel,
    output logic                  penable,
    output logic                  pwrite,
    output logic [31:0]           pwdata,
    input  logic [31:0]           prdata,
    input  logic                  pready,
    input  logic                  pslverr
`ifdef SYSAHB_APB_PSTRB_EN
    ,
    output logic [3:0]            pstrb,
    output logic [2:0]            pprot
`endif
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_ERR1,
        ST_ERR2
    } state_t;

    localparam logic [4:0] NUM_SLAVES_W = 5'(NUM_SLAVES);

    state_t               state_q, state_d;
    logic [PADDR_W-1:0]   paddr_q, paddr_d;
    logic                 pwrite_q, pwrite_d;
    logic [3:0]           idx_q, idx_d;
    logic [31:0]          pwdata_q, pwdata_d;
    logic [31:0]          hrdata_q, hrdata_d;

    logic                 accept;
    logic [3:0]           haddr_idx;
    logic                 slot_ok;
    logic                 size_ok;

`ifdef SYSAHB_APB_PSTRB_EN
    logic [2:0]           hsize_q, hsize_d;
    logic [1:0]           hprot_q, hprot_d;
`endif

    // Folds inputs that carry no function in every build so lint sees them consumed.
    logic unused_inputs;
    assign unused_inputs = ^{htrans[0], haddr, hsize, hprot};

    assign accept    = hsel & hready & htrans[1];
    assign haddr_idx = haddr[SLOT_LSB+3:SLOT_LSB];
    assign slot_ok   = {1'b0, haddr_idx} < NUM_SLAVES_W;

`ifdef SYSAHB_APB_PSTRB_EN
    assign size_ok = (hsize <= 3'd2);
`else
    assign size_ok = 1'b1;
`endif

    // State and datapath registers
    always_ff @(posedge sys_clk or negedge sys_resetn) begin
        if (!sys_resetn) begin
            state_q  <= ST_IDLE;
            paddr_q  <= '0;
            pwrite_q <= 1'b0;
            idx_q    <= '0;
            pwdata_q <= '0;
            hrdata_q <= '0;
`ifdef SYSAHB_APB_PSTRB_EN
            hsize_q  <= '0;
            hprot_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            paddr_q  <= paddr_d;
            pwrite_q <= pwrite_d;
            idx_q    <= idx_d;
            pwdata_q <= pwdata_d;
            hrdata_q <= hrdata_d;
`ifdef SYSAHB_APB_PSTRB_EN
            hsize_q  <= hsize_d;
            hprot_q  <= hprot_d;
`endif
        end
    end

    // Next state. Transfers are only taken in IDLE, so anything presented
    // during ERR2 (which the master must cancel) is never captured.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = (slot_ok && size_ok) ? ST_SETUP : ST_ERR1;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: begin
                if (pready) begin
                    state_d = pslverr ? ST_ERR1 : ST_IDLE;
                end
            end
            ST_ERR1:   state_d = ST_ERR2;
            ST_ERR2:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Captured address phase, write data and read data
    always_comb begin
        paddr_d  = paddr_q;
        pwrite_d = pwrite_q;
        idx_d    = idx_q;
        pwdata_d = pwdata_q;
        hrdata_d = hrdata_q;
`ifdef SYSAHB_APB_PSTRB_EN
        hsize_d  = hsize_q;
        hprot_d  = hprot_q;
`endif
        if (state_q == ST_IDLE && accept) begin
            paddr_d  = haddr[PADDR_W-1:0];
            pwrite_d = hwrite;
            idx_d    = haddr_idx;
`ifdef SYSAHB_APB_PSTRB_EN
            hsize_d  = hsize;
            hprot_d  = hprot[1:0];
`endif
        end
        if (state_q == ST_SETUP) begin
            pwdata_d = hwdata;
        end
        if (state_q == ST_ACCESS && pready && !pslverr && !pwrite_q) begin
            hrdata_d = prdata;
        end
    end

    // Outputs decoded from state
    always_comb begin
        hreadyout = (state_q == ST_IDLE) || (state_q == ST_ERR2);
        hresp     = (state_q == ST_ERR1) || (state_q == ST_ERR2);
        penable   = (state_q == ST_ACCESS);
        psel      = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            psel[i] = ((state_q == ST_SETUP) || (state_q == ST_ACCESS)) && (idx_q == i[3:0]);
        end
        // hwdata is only valid in the data phase, which is the SETUP cycle,
        // so it is forwarded directly then and held from the register after.
        pwdata    = (state_q == ST_SETUP) ? hwdata : pwdata_q;
        paddr     = paddr_q;
        pwrite    = pwrite_q;
        hrdata    = hrdata_q;
    end

`ifdef SYSAHB_APB_PSTRB_EN
    always_comb begin
        pstrb = 4'b0000;
        if (pwrite_q) begin
            case (hsize_q)
                3'd0:    pstrb = 4'b0001 << paddr_q[1:0];
                3'd1:    pstrb = paddr_q[1] ? 4'b1100 : 4'b0011;
                default: pstrb = 4'b1111;
            endcase
        end
        pprot = {~hprot_q[0], 1'b0, hprot_q[1]};
    end
`endif

endmodule

// File: tb/tb_sysahb_apb_bridge.sv
// tb/tb_sysahb_apb_bridge.sv - self-checking bench for sysahb_apb_bridge

module tb_sysahb_apb_bridge;

    localparam int NS   = 8;
    localparam int MAXX = 32;

    logic        sys_clk = 1'b0;
    logic        sys_resetn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [15:0] paddr;
    logic [NS-1:0] psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;
`ifdef SYSAHB_APB_PSTRB_EN
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
`endif

    // Single-slave bus: the bus HREADY is this slave's hreadyout.
    assign hready = hreadyout;

    always #5 sys_clk = ~sys_clk;

    sysahb_apb_bridge #(.NUM_SLAVES(NS), .SLOT_LSB(12), .PADDR_W(16)) dut (
        .sys_clk(sys_clk), .sys_resetn(sys_resetn), .hsel(hsel), .haddr(haddr),
        .htrans(htrans), .hwrite(hwrite), .hsize(hsize), .hprot(hprot),
        .hwdata(hwdata), .hready(hready), .hreadyout(hreadyout), .hresp(hresp),
        .hrdata(hrdata), .paddr(paddr), .psel(psel), .penable(penable),
        .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata), .pready(pready),
        .pslverr(pslverr)
`ifdef SYSAHB_APB_PSTRB_EN
        , .pstrb(pstrb), .pprot(pprot)
`endif
    );

    int n_total = 0;
    int n_bad   = 0;
    logic [31:0] mdl_hrdata;

    // Transfer list for the driver
    int          n_x;
    logic [31:0] t_addr [MAXX];
    logic [31:0] t_wdata[MAXX];
    logic [31:0] t_rdata[MAXX];
    bit          t_wr   [MAXX];
    bit          t_err  [MAXX];
    int          t_waits[MAXX];

    // Observations per transfer
    int          o_low[MAXX], o_hresp_low[MAXX], o_psel_cyc[MAXX], o_pen_cyc[MAXX];
    int          o_setup_pen[MAXX], o_pwdata_bad[MAXX], o_paddr_bad[MAXX], o_pwrite_bad[MAXX];
    logic [NS-1:0] o_psel_or[MAXX];
    bit          o_resp[MAXX], o_done[MAXX];
    logic [31:0] o_hrdata[MAXX];
    int          viol, run_cycles;
    bit          timeout;

    task automatic drive_idle();
        hsel = 1'b0; htrans = 2'b00; haddr = '0; hwrite = 1'b0;
        hsize = 3'd2; hprot = 4'd0;
    endtask

    // AHB master + APB slave; runs t_* back to back and records what it sees.
    task automatic run_xfers();
        int ap, dp, next_dp, acc, cyc;
        logic [NS-1:0] prev_psel;
        logic prev_pen, was_ready;
        ap = 0; dp = -1; acc = 0; cyc = 0; prev_psel = '0; prev_pen = 1'b0;
        viol = 0; timeout = 1'b0;
        for (int k = 0; k < MAXX; k++) begin
            o_low[k] = 0; o_hresp_low[k] = 0; o_psel_cyc[k] = 0; o_pen_cyc[k] = 0;
            o_setup_pen[k] = 0; o_pwdata_bad[k] = 0; o_paddr_bad[k] = 0; o_pwrite_bad[k] = 0;
            o_psel_or[k] = '0; o_resp[k] = 1'b0; o_done[k] = 1'b0; o_hrdata[k] = '0;
        end
        forever begin
            @(posedge sys_clk); #1;
            cyc++;
            was_ready = hreadyout;
            next_dp = dp;
            if (hreadyout) begin
                if (dp >= 0 && hresp) begin
                    // ERR2: a transfer shown here must be ignored by the bridge
                    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0; hwrite = 1'b0;
                    next_dp = -1;
                end else if (ap < n_x) begin
                    hsel = 1'b1; htrans = 2'b10; haddr = t_addr[ap]; hwrite = t_wr[ap];
                    hsize = 3'($urandom_range(0, 2)); hprot = 4'($urandom);
                    next_dp = ap;
                    ap++;
                end else begin
                    drive_idle();
                    next_dp = -1;
                end
            end
            hwdata = (dp >= 0) ? t_wdata[dp] : $urandom;
            if (psel != '0 && penable && dp >= 0) begin
                acc++;
                if (acc > t_waits[dp]) begin
                    pready = 1'b1; pslverr = t_err[dp]; prdata = t_rdata[dp];
                end else begin
                    pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
                end
            end else begin
                acc = 0; pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
            end
            @(negedge sys_clk);
            if (dp >= 0) begin
                if (psel != '0) begin
                    o_psel_cyc[dp]++;
                    o_psel_or[dp] |= psel;
                    if (penable) o_pen_cyc[dp]++;
                    if (penable && o_psel_cyc[dp] == 1) o_setup_pen[dp]++;
                    if (paddr !== t_addr[dp][15:0]) o_paddr_bad[dp]++;
                    if (pwrite !== t_wr[dp]) o_pwrite_bad[dp]++;
                    if (t_wr[dp] && pwdata !== t_wdata[dp]) o_pwdata_bad[dp]++;
                end
                if (!hreadyout) begin
                    o_low[dp]++;
                    if (hresp) o_hresp_low[dp]++;
                end else begin
                    o_resp[dp] = hresp; o_hrdata[dp] = hrdata; o_done[dp] = 1'b1;
                end
            end else if (psel != '0) begin
                viol++;
            end
            if ((psel & (psel - 1'b1)) != '0) viol++;
            if (penable && psel == '0) viol++;
            if (prev_pen && psel != '0 && (!penable || psel != prev_psel)) viol++;
            prev_psel = psel; prev_pen = penable;
            if (was_ready) dp = next_dp;
            if (dp < 0 && ap >= n_x) break;
            if (cyc > 1000) begin timeout = 1'b1; break; end
        end
        run_cycles = cyc;
        drive_idle();
        @(posedge sys_clk); @(negedge sys_clk);
        if (psel != '0 || !hreadyout) viol++;
        n_total++;
        if (timeout) begin
            n_bad++;
            $display("FAIL run_timeout: cycles=%0d required completion within 1000", cyc);
        end
    endtask

    task automatic test_reset();
        sys_resetn = 1'b0; drive_idle(); hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        n_total++;
        if ({hreadyout, hresp, penable, pwrite} !== 4'b1000) begin
            n_bad++; $display("FAIL reset_ctl: got %b want 1000", {hreadyout, hresp, penable, pwrite});
        end
        n_total++;
        if (psel !== '0 || paddr !== '0) begin
            n_bad++; $display("FAIL reset_apb: psel=%b paddr=%h want 0/0", psel, paddr);
        end
        n_total++;
        if (hrdata !== '0 || pwdata !== '0) begin
            n_bad++; $display("FAIL reset_data: hrdata=%h pwdata=%h want 0/0", hrdata, pwdata);
        end
        sys_resetn = 1'b1;
        mdl_hrdata = '0;
    endtask

    task automatic test_read_slot2();
        n_x = 1;
        t_addr[0] = 32'h0000_2010; t_wr[0] = 1'b0; t_waits[0] = 0; t_err[0] = 1'b0;
        t_rdata[0] = 32'hDEAD_BEEF; t_wdata[0] = $urandom;
        run_xfers();
        mdl_hrdata = 32'hDEAD_BEEF;
        n_total++;
        if (o_psel_or[0] !== 8'b0000_0100 || o_psel_cyc[0] != 2) begin
            n_bad++; $display("FAIL rd2_psel: got %b x%0d want 00000100 x2", o_psel_or[0], o_psel_cyc[0]);
        end
        n_total++;
        if (o_pen_cyc[0] != 1 || o_setup_pen[0] != 0) begin
            n_bad++; $display("FAIL rd2_penable: got %0d/%0d want 1/0", o_pen_cyc[0], o_setup_pen[0]);
        end
        n_total++;
        if (o_low[0] != 2 || run_cycles != 4) begin
            n_bad++; $display("FAIL rd2_latency: waits=%0d cycles=%0d want 2/4", o_low[0], run_cycles);
        end
        n_total++;
        if (!o_done[0] || o_resp[0] !== 1'b0 || o_hrdata[0] !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL rd2_data: resp=%b hrdata=%h want 0/deadbeef", o_resp[0], o_hrdata[0]);
        end
        n_total++;
        if (o_paddr_bad[0] != 0 || viol != 0) begin
            n_bad++; $display("FAIL rd2_proto: paddr_bad=%0d viol=%0d want 0/0", o_paddr_bad[0], viol);
        end
    endtask

    task automatic test_write_wait();
        n_x = 1;
        t_addr[0] = 32'h0000_0040; t_wr[0] = 1'b1; t_waits[0] = 3; t_err[0] = 1'b0;
        t_wdata[0] = 32'h1234_5678; t_rdata[0] = $urandom;
        run_xfers();
        n_total++;
        if (o_low[0] != 5 || o_psel_cyc[0] != 5 || o_psel_or[0] !== 8'b0000_0001) begin
            n_bad++; $display("FAIL wr_wait: low=%0d psel=%b x%0d want 5, 00000001 x5",
                              o_low[0], o_psel_or[0], o_psel_cyc[0]);
        end
        n_total++;
        if (o_pwdata_bad[0] != 0 || o_pwrite_bad[0] != 0) begin
            n_bad++; $display("FAIL wr_pwdata: bad=%0d pwrite_bad=%0d want 0/0", o_pwdata_bad[0], o_pwrite_bad[0]);
        end
        n_total++;
        if (o_resp[0] !== 1'b0 || o_hrdata[0] !== mdl_hrdata) begin
            n_bad++; $display("FAIL wr_resp: resp=%b hrdata=%h want 0/%h", o_resp[0], o_hrdata[0], mdl_hrdata);
        end
    endtask

    task automatic test_slverr();
        n_x = 1;
        t_addr[0] = 32'h0000_4008; t_wr[0] = 1'b0; t_waits[0] = 1; t_err[0] = 1'b1;
        t_rdata[0] = $urandom; t_wdata[0] = $urandom;
        run_xfers();
        n_total++;
        if (o_low[0] != 4 || o_hresp_low[0] != 1 || o_resp[0] !== 1'b1) begin
            n_bad++; $display("FAIL slverr_resp: low=%0d hresp_low=%0d resp=%b want 4/1/1",
                              o_low[0], o_hresp_low[0], o_resp[0]);
        end
        n_total++;
        if (o_psel_cyc[0] != 3 || viol != 0) begin
            n_bad++; $display("FAIL slverr_psel: cycles=%0d viol=%0d want 3/0", o_psel_cyc[0], viol);
        end
        n_total++;
        if (o_hrdata[0] !== mdl_hrdata) begin
            n_bad++; $display("FAIL slverr_hrdata: got %h want %h", o_hrdata[0], mdl_hrdata);
        end
    endtask

    task automatic test_bad_slot();
        n_x = 1;
        t_addr[0] = 32'h0000_9000; t_wr[0] = 1'b0; t_waits[0] = 0; t_err[0] = 1'b0;
        t_rdata[0] = $urandom; t_wdata[0] = $urandom;
        run_xfers();
        n_total++;
        if (o_psel_or[0] !== '0 || o_psel_cyc[0] != 0) begin
            n_bad++; $display("FAIL badslot_psel: got %b x%0d want 0 x0", o_psel_or[0], o_psel_cyc[0]);
        end
        n_total++;
        if (o_low[0] != 1 || o_hresp_low[0] != 1 || o_resp[0] !== 1'b1) begin
            n_bad++; $display("FAIL badslot_resp: low=%0d hresp_low=%0d resp=%b want 1/1/1",
                              o_low[0], o_hresp_low[0], o_resp[0]);
        end
    endtask

    task automatic test_back_to_back();
        n_x = 2;
        t_addr[0] = 32'h0000_1004; t_wr[0] = 1'b1; t_waits[0] = 0; t_err[0] = 1'b0;
        t_wdata[0] = $urandom; t_rdata[0] = $urandom;
        t_addr[1] = 32'h0000_300C; t_wr[1] = 1'b0; t_waits[1] = 0; t_err[1] = 1'b0;
        t_wdata[1] = $urandom; t_rdata[1] = $urandom;
        run_xfers();
        mdl_hrdata = t_rdata[1];
        n_total++;
        if (run_cycles != 7 || viol != 0) begin
            n_bad++; $display("FAIL b2b_timing: cycles=%0d viol=%0d want 7/0", run_cycles, viol);
        end
        for (int k = 0; k < 2; k++) begin
            n_total++;
            if (o_low[k] != 2 || o_resp[k] !== 1'b0 || o_psel_or[k] !== 8'(1 << t_addr[k][15:12])) begin
                n_bad++; $display("FAIL b2b_xfer[%0d]: low=%0d resp=%b psel=%b", k, o_low[k], o_resp[k], o_psel_or[k]);
            end
        end
        n_total++;
        if (o_pwdata_bad[0] != 0 || o_hrdata[1] !== t_rdata[1]) begin
            n_bad++; $display("FAIL b2b_data: pwdata_bad=%0d hrdata=%h want 0/%h", o_pwdata_bad[0], o_hrdata[1], t_rdata[1]);
        end
    endtask

    task automatic test_random();
        int exp_cyc, e_low, e_pc;
        bit bad_slot, e_err;
        logic [3:0] idx;
        logic [NS-1:0] e_psel;
        n_x = 24;
        for (int k = 0; k < n_x; k++) begin
            t_addr[k] = $urandom;
            t_addr[k][15:12] = 4'($urandom_range(0, 11));
            t_wr[k] = 1'($urandom); t_waits[k] = $urandom_range(0, 3);
            t_err[k] = ($urandom_range(0, 4) == 0);
            t_wdata[k] = $urandom; t_rdata[k] = $urandom;
        end
        run_xfers();
        exp_cyc = 1;
        for (int k = 0; k < n_x; k++) begin
            idx = t_addr[k][15:12];
            bad_slot = (int'(idx) >= NS);
            e_err = bad_slot || t_err[k];
            e_low = bad_slot ? 1 : (2 + t_waits[k] + (t_err[k] ? 1 : 0));
            e_pc = bad_slot ? 0 : 2 + t_waits[k];
            e_psel = bad_slot ? '0 : NS'(1 << idx);
            if (!e_err && !t_wr[k]) mdl_hrdata = t_rdata[k];
            exp_cyc += e_low + 1 + ((e_err && k < n_x - 1) ? 1 : 0);
            n_total++;
            if (o_low[k] != e_low || o_resp[k] !== e_err || o_hresp_low[k] != (e_err ? 1 : 0)) begin
                n_bad++; $display("FAIL rnd_resp[%0d]: low=%0d resp=%b hresp_low=%0d want %0d/%b/%0d",
                                  k, o_low[k], o_resp[k], o_hresp_low[k], e_low, e_err, e_err ? 1 : 0);
            end
            n_total++;
            if (o_psel_or[k] !== e_psel || o_psel_cyc[k] != e_pc || o_pen_cyc[k] != (bad_slot ? 0 : e_pc - 1)) begin
                n_bad++; $display("FAIL rnd_psel[%0d]: psel=%b x%0d pen=%0d want %b x%0d",
                                  k, o_psel_or[k], o_psel_cyc[k], o_pen_cyc[k], e_psel, e_pc);
            end
            n_total++;
            if (o_hrdata[k] !== mdl_hrdata || !o_done[k]) begin
                n_bad++; $display("FAIL rnd_hrdata[%0d]: got %h done=%b want %h", k, o_hrdata[k], o_done[k], mdl_hrdata);
            end
            n_total++;
            if (o_pwdata_bad[k] + o_paddr_bad[k] + o_pwrite_bad[k] + o_setup_pen[k] != 0) begin
                n_bad++; $display("FAIL rnd_apb[%0d]: pwdata_bad=%0d paddr_bad=%0d pwrite_bad=%0d setup_pen=%0d want 0",
                                  k, o_pwdata_bad[k], o_paddr_bad[k], o_pwrite_bad[k], o_setup_pen[k]);
            end
        end
        n_total++;
        if (run_cycles != exp_cyc || viol != 0) begin
            n_bad++; $display("FAIL rnd_total: cycles=%0d viol=%0d want %0d/0", run_cycles, viol, exp_cyc);
        end
    endtask

    task automatic test_reset_mid();
        @(posedge sys_clk); #1;
        hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_5000; hwrite = 1'b1; pready = 1'b0;
        @(posedge sys_clk); #1;
        drive_idle(); hwdata = $urandom;
        @(posedge sys_clk); #1;
        n_total++;
        if (penable !== 1'b1 || psel !== 8'b0010_0000) begin
            n_bad++; $display("FAIL rstmid_access: penable=%b psel=%b want 1/00100000", penable, psel);
        end
        sys_resetn = 1'b0;
        #1;
        n_total++;
        if (psel !== '0 || penable !== 1'b0 || hreadyout !== 1'b1 || hresp !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_abort: psel=%b penable=%b hreadyout=%b hresp=%b want 0/0/1/0",
                              psel, penable, hreadyout, hresp);
        end
        repeat (2) @(posedge sys_clk);
        #1;
        sys_resetn = 1'b1; mdl_hrdata = '0; pready = 1'b1;
        @(posedge sys_clk); #1;
        hsel = 1'b1; htrans = 2'b00;
        @(negedge sys_clk);
        n_total++;
        if (hreadyout !== 1'b1 || hresp !== 1'b0 || psel !== '0 || penable !== 1'b0) begin
            n_bad++; $display("FAIL rstmid_idle: hreadyout=%b hresp=%b psel=%b penable=%b want 1/0/0/0",
                              hreadyout, hresp, psel, penable);
        end
        @(posedge sys_clk); #1;
        drive_idle();
        @(negedge sys_clk);
        n_total++;
        if (psel !== '0 || hreadyout !== 1'b1 || hrdata !== mdl_hrdata) begin
            n_bad++; $display("FAIL rstmid_after: psel=%b hreadyout=%b hrdata=%h want 0/1/%h",
                              psel, hreadyout, hrdata, mdl_hrdata);
        end
    endtask

    initial begin
        test_reset();
        test_read_slot2();
        test_write_wait();
        test_slverr();
        test_bad_slot();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
